// File: rtl/arduino_mem_bridge.sv
// Bridge from the 8-bit Arduino strobe bus to NUM_CH single-port block memories.
// Bytes shift into a header register; a commit strobe performs one read or write.
//
// state   | meaning
// IDLE    | waiting for a commit edge, host sees finished
// ACCESS  | one-cycle ce/wre pulse to the selected channel (or error on bad channel)
// WAIT    | extra memory read latency cycles (RD_LAT > 1 only)
// CAPTURE | register the selected channel's read data into arduino_datain
// DONE    | pointer auto-increment and error clear, host sees finished
module arduino_mem_bridge #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 14,
  parameter int RD_LAT      = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                       sysclk,
  input  logic                       arduino_reset,
  input  logic [7:0]                 arduino_dataout,
  input  logic                       arduino_shiftin,
  input  logic                       arduino_readwrite,
  input  logic                       arduino_commit,
  output logic [7:0]                 arduino_datain,
  output logic                       arduino_isfinished,
  output logic                       bridge_error,
  input  logic [NUM_CH*8-1:0]        mem_dout,
  output logic [NUM_CH*8-1:0]        mem_din,
  output logic [NUM_CH*ADDR_W-1:0]   mem_ad,
  output logic [NUM_CH-1:0]          mem_ce,
  output logic [NUM_CH-1:0]          mem_wre,
  output logic [NUM_CH-1:0]          mem_oce
);
  localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
  localparam int NB         = 2 + ADDR_BYTES;
  localparam int SR_W       = 8 * NB;
  localparam int HDR_W      = 8 * (ADDR_BYTES + 1);
  localparam int CNT_W      = $clog2(NB + 1);
  localparam int WAIT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ACCESS, WAIT, CAPTURE, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] shift_sync, commit_sync, rw_sync;
  logic                   shift_prev, commit_prev;
  logic                   shift_edge, commit_edge, commit_go, rw_s;

  logic [SR_W-1:0]   sr_q, sr_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic [HDR_W-1:0]  hdr;
  logic              hdr_full;
  logic [6:0]        ptr_ch;
  logic              ptr_ai;
  logic [ADDR_W-1:0] ptr_addr;
  logic [7:0]        data_q;
  logic              rw_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [7:0]        rd_byte;
  logic [NUM_CH-1:0] ch_onehot;
  logic              ch_valid;
  logic              unused_hdr_bits;

  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) begin
      shift_sync  <= '0;
      commit_sync <= '0;
      rw_sync     <= '0;
      shift_prev  <= 1'b0;
      commit_prev <= 1'b0;
    end else begin
      shift_sync  <= {shift_sync[SYNC_STAGES-2:0], arduino_shiftin};
      commit_sync <= {commit_sync[SYNC_STAGES-2:0], arduino_commit};
      rw_sync     <= {rw_sync[SYNC_STAGES-2:0], arduino_readwrite};
      shift_prev  <= shift_sync[SYNC_STAGES-1];
      commit_prev <= commit_sync[SYNC_STAGES-1];
    end
  end

  assign shift_edge  = shift_sync[SYNC_STAGES-1] & ~shift_prev;
  assign commit_edge = commit_sync[SYNC_STAGES-1] & ~commit_prev;
  assign rw_s        = rw_sync[SYNC_STAGES-1];
  assign commit_go   = commit_edge && (state_q == IDLE);

  // A shift in the commit cycle is folded in before the header is decoded.
  always_comb begin
    sr_nxt  = sr_q;
    cnt_nxt = cnt_q;
    if (shift_edge) begin
      sr_nxt = {sr_q[SR_W-9:0], arduino_dataout};
      if (cnt_q != CNT_W'(NB)) cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  assign hdr      = rw_s ? sr_nxt[SR_W-1:8] : sr_nxt[HDR_W-1:0];
  assign hdr_full = cnt_nxt >= (rw_s ? CNT_W'(NB) : CNT_W'(NB - 1));
  assign unused_hdr_bits = ^hdr;

  always_comb begin
    rd_byte   = '0;
    ch_onehot = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ptr_ch == 7'(k)) begin
        rd_byte      = mem_dout[8*k +: 8];
        ch_onehot[k] = 1'b1;
      end
    end
  end

  assign ch_valid = |ch_onehot;

  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) begin
      sr_q           <= '0;
      cnt_q          <= '0;
      ptr_ch         <= '0;
      ptr_ai         <= 1'b0;
      ptr_addr       <= '0;
      data_q         <= '0;
      rw_q           <= 1'b0;
      wait_cnt       <= '0;
      arduino_datain <= '0;
      bridge_error   <= 1'b0;
    end else begin
      sr_q  <= sr_nxt;
      cnt_q <= commit_go ? '0 : cnt_nxt;
      if (commit_go) begin
        rw_q   <= rw_s;
        data_q <= sr_nxt[7:0];
        if (hdr_full) begin
          ptr_ai   <= hdr[HDR_W-1];
          ptr_ch   <= hdr[HDR_W-2 -: 7];
          ptr_addr <= hdr[ADDR_W-1:0];
        end
      end
      case (state_q)
        ACCESS: begin
          if (!ch_valid) bridge_error <= 1'b1;
          wait_cnt <= WAIT_W'(RD_LAT - 1);
        end
        WAIT:    wait_cnt <= wait_cnt - WAIT_W'(1);
        CAPTURE: arduino_datain <= rd_byte;
        DONE: begin
          if (ch_valid) begin
            bridge_error <= 1'b0;
            if (ptr_ai) ptr_addr <= ptr_addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sysclk or posedge arduino_reset) begin
    if (arduino_reset) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    arduino_isfinished = 1'b1;
    mem_ce             = '0;
    case (state_q)
      IDLE: if (commit_edge) state_d = ACCESS;
      ACCESS: begin
        arduino_isfinished = 1'b0;
        mem_ce             = ch_onehot;
        if (!ch_valid || rw_q) state_d = DONE;
        else if (RD_LAT > 1)   state_d = WAIT;
        else                   state_d = CAPTURE;
      end
      WAIT: begin
        arduino_isfinished = 1'b0;
        if (wait_cnt == WAIT_W'(1)) state_d = CAPTURE;
      end
      CAPTURE: begin
        arduino_isfinished = 1'b0;
        state_d            = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign mem_wre = mem_ce & {NUM_CH{rw_q}};
  assign mem_ad  = {NUM_CH{ptr_addr}};
  assign mem_din = {NUM_CH{data_q}};
  assign mem_oce = '1;
endmodule

// File: tb/tb_arduino_mem_bridge.sv
// Bench for arduino_mem_bridge: directed scenarios plus randomized transactions
// checked against a byte-level model of the host protocol and memory contents.
module tb_arduino_mem_bridge;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 14;
  localparam int DEPTH  = 1 << ADDR_W;

  logic                     sysclk = 1'b0;
  logic                     arduino_reset = 1'b0;
  logic [7:0]               arduino_dataout = '0;
  logic                     arduino_shiftin = 1'b0;
  logic                     arduino_readwrite = 1'b0;
  logic                     arduino_commit = 1'b0;
  logic [7:0]               arduino_datain;
  logic                     arduino_isfinished;
  logic                     bridge_error;
  logic [NUM_CH*8-1:0]      mem_dout = '0;
  logic [NUM_CH*8-1:0]      mem_din;
  logic [NUM_CH*ADDR_W-1:0] mem_ad;
  logic [NUM_CH-1:0]        mem_ce, mem_wre, mem_oce;

  arduino_mem_bridge #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .RD_LAT(1), .SYNC_STAGES(2)) dut (
    .sysclk(sysclk), .arduino_reset(arduino_reset), .arduino_dataout(arduino_dataout),
    .arduino_shiftin(arduino_shiftin), .arduino_readwrite(arduino_readwrite),
    .arduino_commit(arduino_commit), .arduino_datain(arduino_datain),
    .arduino_isfinished(arduino_isfinished), .bridge_error(bridge_error),
    .mem_dout(mem_dout), .mem_din(mem_din), .mem_ad(mem_ad), .mem_ce(mem_ce),
    .mem_wre(mem_wre), .mem_oce(mem_oce)
  );

  always #5 sysclk = ~sysclk;

  // Block memories, one-cycle read latency
  logic [7:0] mem [NUM_CH][DEPTH];
  always @(posedge sysclk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (mem_ce[k]) begin
        if (mem_wre[k]) mem[k][mem_ad[k*ADDR_W +: ADDR_W]] <= mem_din[8*k +: 8];
        else            mem_dout[8*k +: 8] <= mem[k][mem_ad[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  int          acc_cycles = 0;
  logic [3:0]  last_ce, last_wre;
  logic [13:0] last_ad;
  logic [7:0]  last_din;
  always @(posedge sysclk) begin
    if (|mem_ce) begin
      acc_cycles++;
      last_ce  = mem_ce;
      last_wre = mem_wre;
      last_ad  = mem_ad[ADDR_W-1:0];
      last_din = mem_din[7:0];
    end
  end

  // Reference model state
  logic [7:0] mdl [NUM_CH][DEPTH];
  logic [7:0] sr_m [4];
  int         cnt_m, ch_m, addr_m;
  bit         ai_m, err_m;
  logic [7:0] datain_m;

  int chk_total = 0;
  int chk_pass  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_total++;
    assert (obs === exp) begin
      chk_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) sr_m[i] = '0;
    cnt_m = 0; ch_m = 0; addr_m = 0; ai_m = 0; err_m = 0; datain_m = '0;
  endtask

  task automatic model_shift(input logic [7:0] b);
    for (int i = 3; i > 0; i--) sr_m[i] = sr_m[i-1];
    sr_m[0] = b;
    if (cnt_m < 4) cnt_m++;
  endtask

  task automatic shift_byte(input logic [7:0] b);
    arduino_dataout = b;
    arduino_shiftin = 1'b1;
    model_shift(b);
    tick(4);
    arduino_shiftin = 1'b0;
    tick(4);
  endtask

  task automatic do_commit(input bit rw, input bit with_byte, input logic [7:0] b,
                           input bit dbl, input string tag);
    int         acc0, busy, exp_busy;
    bit         valid;
    logic [7:0] chb, data;
    if (with_byte) begin
      arduino_dataout = b;
      arduino_shiftin = 1'b1;
      model_shift(b);
    end
    arduino_readwrite = rw;
    arduino_commit    = 1'b1;
    if (cnt_m >= 3 + int'(rw)) begin
      if (rw) begin addr_m = {sr_m[2], sr_m[1]} % DEPTH; chb = sr_m[3]; end
      else    begin addr_m = {sr_m[1], sr_m[0]} % DEPTH; chb = sr_m[2]; end
      ch_m = int'(chb[6:0]);
      ai_m = chb[7];
    end
    data  = sr_m[0];
    cnt_m = 0;
    valid = ch_m < NUM_CH;
    exp_busy = (valid && !rw) ? 2 : 1;
    if (valid) begin
      if (rw) mdl[ch_m][addr_m] = data;
      else    datain_m = mdl[ch_m][addr_m];
      err_m = 0;
    end else begin
      err_m = 1;
    end
    acc0 = acc_cycles;
    busy = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sysclk);
      if (dbl && i == 0) arduino_commit = 1'b0;
      if (dbl && i == 1) arduino_commit = 1'b1;
      if (i == 5) begin arduino_commit = 1'b0; arduino_shiftin = 1'b0; end
      if (!arduino_isfinished) busy++;
    end
    check({tag, "/busy"}, busy, exp_busy);
    check({tag, "/acc_cycles"}, acc_cycles - acc0, valid ? 1 : 0);
    if (valid) begin
      check({tag, "/ce"}, last_ce, 32'(1) << ch_m);
      check({tag, "/wre"}, last_wre, rw ? (32'(1) << ch_m) : 0);
      check({tag, "/ad"}, last_ad, addr_m);
      if (rw) check({tag, "/din"}, last_din, data);
    end
    check({tag, "/datain"}, arduino_datain, datain_m);
    check({tag, "/error"}, bridge_error, err_m);
    if (valid && ai_m) addr_m = (addr_m + 1) % DEPTH;
  endtask

  initial begin
    logic [7:0] v, chb, ahi, alo;
    int         kind, a;
    for (int k = 0; k < NUM_CH; k++)
      for (int i = 0; i < DEPTH; i++) begin
        v = 8'($urandom);
        mem[k][i] = v;
        mdl[k][i] = v;
      end
    model_reset();

    #1 arduino_reset = 1'b1;
    #1;
    check("reset/datain", arduino_datain, 8'h00);
    check("reset/isfinished", arduino_isfinished, 1);
    check("reset/error", bridge_error, 0);
    check("reset/ce", mem_ce, 0);
    tick(3);
    arduino_reset = 1'b0;
    tick(3);

    shift_byte(8'h02); shift_byte(8'h01); shift_byte(8'h23); shift_byte(8'hA5);
    do_commit(1, 0, 8'h00, 0, "wr_full");

    shift_byte(8'h02); shift_byte(8'h01); shift_byte(8'h23);
    do_commit(0, 0, 8'h00, 0, "rd_back");

    shift_byte(8'h81); shift_byte(8'h3F); shift_byte(8'hFF); shift_byte(8'h11);
    do_commit(1, 0, 8'h00, 0, "ai_wr_top");
    shift_byte(8'h22);
    do_commit(1, 0, 8'h00, 0, "ai_wr_wrap");
    do_commit(0, 0, 8'h00, 0, "ai_rd_bare");

    shift_byte(8'h05); shift_byte(8'h00); shift_byte(8'h00); shift_byte(8'h77);
    do_commit(1, 0, 8'h00, 0, "bad_ch");
    shift_byte(8'h00); shift_byte(8'h00); shift_byte(8'h05); shift_byte(8'h33);
    do_commit(1, 0, 8'h00, 0, "err_clear");

    shift_byte(8'h02); shift_byte(8'h01); shift_byte(8'h23);
    do_commit(0, 0, 8'h00, 1, "busy_dbl");

    shift_byte(8'h03); shift_byte(8'h00); shift_byte(8'h40);
    do_commit(1, 1, 8'h9C, 0, "simul_wr");
    shift_byte(8'h03); shift_byte(8'h00); shift_byte(8'h40);
    do_commit(0, 0, 8'h00, 0, "simul_rd");

    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      chb  = 8'($urandom_range(0, 5)) | ($urandom_range(0, 1) ? 8'h80 : 8'h00);
      a    = $urandom_range(0, 1) ? $urandom_range(0, 7) : 16'h3FF8 + $urandom_range(0, 7);
      ahi  = 8'(a >> 8) | 8'($urandom_range(0, 3) << 6);
      alo  = 8'(a);
      v    = 8'($urandom);
      case (kind)
        0: begin
          shift_byte(chb); shift_byte(ahi); shift_byte(alo);
          if ($urandom_range(0, 1)) do_commit(1, 1, v, 0, "rnd_wr_simul");
          else begin shift_byte(v); do_commit(1, 0, 8'h00, 0, "rnd_wr"); end
        end
        1: begin
          shift_byte(chb); shift_byte(ahi); shift_byte(alo);
          do_commit(0, 0, 8'h00, 0, "rnd_rd");
        end
        2: do_commit(1, 1, v, 0, "rnd_wr_bare");
        default: do_commit(0, 0, 8'h00, 0, "rnd_rd_bare");
      endcase
    end

    shift_byte(8'h01); shift_byte(8'h00); shift_byte(8'h10); shift_byte(8'h5A);
    arduino_readwrite = 1'b1;
    arduino_commit    = 1'b1;
    for (int i = 0; i < 10 && arduino_isfinished; i++) @(negedge sysclk);
    check("rst_mid/reach_access", arduino_isfinished, 0);
    #2 arduino_reset = 1'b1;
    #1;
    check("rst_mid/datain", arduino_datain, 8'h00);
    check("rst_mid/isfinished", arduino_isfinished, 1);
    check("rst_mid/ce", mem_ce, 0);
    check("rst_mid/wre", mem_wre, 0);
    check("rst_mid/error", bridge_error, 0);
    check("rst_mid/ad", mem_ad, 0);
    check("rst_mid/din", mem_din, 0);
    arduino_commit = 1'b0;
    model_reset();
    tick(6);
    arduino_reset = 1'b0;
    tick(4);
    do_commit(0, 0, 8'h00, 0, "post_rst_rd");

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end
endmodule
